// File: rtl/axil_cmd_master.sv
// axil_cmd_master
// ---------------------------------------------------------------------------
// Single-outstanding AXI-Lite master. Each command taken from the cmd stream
// becomes one AXI-Lite read or write. Its completion is returned on the rsp
// stream. Data is fixed at 32 bits and the strobe at 4 bits.
//
// Optional feature macro: AXIL_CMD_MASTER_TIMEOUT_EN
//   When defined, a hung transaction is aborted after TIMEOUT_CYCLES cycles.
//   The abort returns rspResp = 2'b11 and rspData = 32'hDEADBEEF. This is a
//   debug escape only, and it leaves the AXI handshake incomplete.
//   When undefined, the master waits on the slave forever.
//
// Parameters
//   ADDR_W          command / AXI address width
//   TIMEOUT_CYCLES  abort threshold (timeout build only, >= 2)
//
// Ports
//   aclk, areset        clock; synchronous active-high reset
//   cmd*                command stream: Valid/Ready, Write, Addr, Data, Strb
//   rsp*                response stream: Valid/Ready, Write, Data, Resp
//   aw*, w*, b*         AXI-Lite write address / data / response channels
//   ar*, r*             AXI-Lite read address / data channels
// ---------------------------------------------------------------------------
module axil_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              aclk,
    input  logic              areset,

    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic              cmdWrite,
    input  logic [ADDR_W-1:0] cmdAddr,
    input  logic [31:0]       cmdData,
    input  logic [3:0]        cmdStrb,

    output logic              rspValid,
    input  logic              rspReady,
    output logic              rspWrite,
    output logic [31:0]       rspData,
    output logic [1:0]        rspResp,

    output logic              awValid,
    input  logic              awReady,
    output logic [ADDR_W-1:0] awAddr,

    output logic              wValid,
    input  logic              wReady,
    output logic [31:0]       wData,
    output logic [3:0]        wStrb,

    input  logic              bValid,
    output logic              bReady,
    input  logic [1:0]        bResp,

    output logic              arValid,
    input  logic              arReady,
    output logic [ADDR_W-1:0] arAddr,

    input  logic              rValid,
    output logic              rReady,
    input  logic [31:0]       rData,
    input  logic [1:0]        rResp
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    state_t state;

    // Per-channel completion flags for the independent AW and W handshakes.
    logic aw_done;
    logic w_done;

    // Elaboration-time sanity check on the abort threshold.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("axil_cmd_master: TIMEOUT_CYCLES must be at least 2");
    end

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    // The counter never needs to hold more than TIMEOUT_CYCLES-1.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] wait_cnt;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= IDLE;
            cmdReady <= 1'b0;
            rspValid <= 1'b0;
            rspWrite <= 1'b0;
            rspData  <= '0;
            rspResp  <= '0;
            awValid  <= 1'b0;
            awAddr   <= '0;
            wValid   <= 1'b0;
            wData    <= '0;
            wStrb    <= '0;
            bReady   <= 1'b0;
            arValid  <= 1'b0;
            arAddr   <= '0;
            rReady   <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmdValid && cmdReady) begin
                        cmdReady <= 1'b0;
                        // Latch the direction now, so that a timeout abort
                        // can also echo it.
                        rspWrite <= cmdWrite;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                        if (cmdWrite) begin
                            awAddr  <= cmdAddr;
                            wData   <= cmdData;
                            wStrb   <= cmdStrb;
                            awValid <= 1'b1;
                            wValid  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            state   <= WR_REQ;
                        end else begin
                            arAddr  <= cmdAddr;
                            arValid <= 1'b1;
                            state   <= RD_REQ;
                        end
                    end else begin
                        // After reset, cmdReady rises one cycle after release.
                        cmdReady <= 1'b1;
                    end
                end

                WR_REQ: begin
                    if (awValid && awReady) begin
                        awValid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (wValid && wReady) begin
                        wValid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    // The flags are registered, so bReady rises one cycle
                    // after the later of the two handshakes.
                    if (aw_done && w_done) begin
                        bReady <= 1'b1;
                        state  <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (bValid && bReady) begin
                        bReady   <= 1'b0;
                        rspResp  <= bResp;
                        rspData  <= '0;
                        rspValid <= 1'b1;
                        state    <= RSP;
                    end
                end

                RD_REQ: begin
                    if (arValid && arReady) begin
                        arValid <= 1'b0;
                        rReady  <= 1'b1;
                        state   <= RD_RESP;
                    end
                end

                RD_RESP: begin
                    if (rValid && rReady) begin
                        rReady   <= 1'b0;
                        rspData  <= rData;
                        rspResp  <= rResp;
                        rspValid <= 1'b1;
                        state    <= RSP;
                    end
                end

                RSP: begin
                    if (rspReady) begin
                        rspValid <= 1'b0;
                        cmdReady <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
            // This is placed after the case so that an abort overrides any
            // channel update made on the same edge.
            if (state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP}) begin
                if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    awValid  <= 1'b0;
                    wValid   <= 1'b0;
                    bReady   <= 1'b0;
                    arValid  <= 1'b0;
                    rReady   <= 1'b0;
                    rspResp  <= 2'b11;
                    rspData  <= 32'hDEAD_BEEF;
                    rspValid <= 1'b1;
                    state    <= RSP;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule
